mux_n_1_stream_arb: RTL and testbench

Parametrised N-channel, WIDTH-bit streaming multiplexer with a registered output and valid/ready handshakes on every channel. It succeeds the fixed 4:1 8-bit combinational mux. It adds two selection modes: fixed select (driven by i_sel_code) and round-robin arbitration. It sits between multiple code producers and a single downstream consumer in the datapath.

---
 rtl/mux_n_1_stream_arb.sv | 105 ++++++++++
 tb/tb_mux_n_1_stream_arb.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_n_1_stream_arb.sv
// mux_n_1_stream_arb
//   N_CH-channel, WIDTH-bit streaming multiplexer with a registered output.
//   A channel is chosen either by a fixed select code (i_mode=0) or by
//   round-robin arbitration (i_mode=1). The round-robin scan starts one past
//   the last channel granted in round-robin mode.
//
// Ports
//   i_clk       clock, rising edge
//   i_rst       synchronous active-high reset
//   i_en        enable; low blocks new accepts, output may still drain
//   i_mode      0 = fixed select, 1 = round-robin
//   i_sel_code  channel index used in fixed mode
//   i_code      packed channel data, channel k = [k*WIDTH +: WIDTH]
//   i_valid     per-channel valid
//   o_ready     per-channel accept strobe (one-hot or zero)
//   o_code      registered output data
//   o_ch        channel index that sourced o_code
//   o_valid     output valid
//   i_ready     downstream ready
module mux_n_1_stream_arb #(
  parameter int WIDTH = 8,
  parameter int N_CH  = 4,
  parameter int SEL_W = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_mode,
  input  logic [SEL_W-1:0]      i_sel_code,
  input  logic [N_CH*WIDTH-1:0] i_code,
  input  logic [N_CH-1:0]       i_valid,
  output logic [N_CH-1:0]       o_ready,
  output logic [WIDTH-1:0]      o_code,
  output logic [SEL_W-1:0]      o_ch,
  output logic                  o_valid,
  input  logic                  i_ready
);

  logic [SEL_W-1:0] rr_last;
  logic             grant_vld;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic             load;
  logic             xfer;

  // Output register can take a new word when it is empty or being popped.
  assign load = i_en & ~i_rst & (~o_valid | i_ready);
  assign xfer = load & grant_vld;

  always_comb begin : grant_sel
    int unsigned idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    if (!i_mode) begin
      // Loop compare keeps out-of-range select codes from indexing i_valid.
      for (int unsigned k = 0; k < N_CH; k++) begin
        if (32'(i_sel_code) == k && i_valid[k]) begin
          grant_vld = 1'b1;
          grant_idx = i_sel_code;
        end
      end
    end else begin
      // Scan offsets 1..N_CH from rr_last; offset N_CH revisits rr_last itself.
      for (int unsigned off = 1; off <= N_CH; off++) begin
        idx = (32'(rr_last) + off) % N_CH;
        if (!grant_vld && i_valid[idx]) begin
          grant_vld = 1'b1;
          grant_idx = SEL_W'(idx);
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    o_ready    = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (32'(grant_idx) == k) begin
        grant_data = i_code[k*WIDTH +: WIDTH];
        o_ready[k] = xfer;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_code  <= '0;
      o_ch    <= '0;
      rr_last <= SEL_W'(N_CH - 1);
    end else if (xfer) begin
      o_valid <= 1'b1;
      o_code  <= grant_data;
      o_ch    <= grant_idx;
      if (i_mode) begin
        rr_last <= grant_idx;
      end
    end else if (o_valid && i_ready) begin
      // Pop with nothing to replace it: covers both "no grant" and i_en low.
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_n_1_stream_arb.sv
module tb_mux_n_1_stream_arb;

  localparam int W = 8;
  localparam int N = 4;
  localparam int S = 2;

  logic           i_clk = 1'b0;
  logic           i_rst;
  logic           i_en;
  logic           i_mode;
  logic [S-1:0]   i_sel_code;
  logic [N*W-1:0] i_code;
  logic [N-1:0]   i_valid;
  logic [N-1:0]   o_ready;
  logic [W-1:0]   o_code;
  logic [S-1:0]   o_ch;
  logic           o_valid;
  logic           i_ready;

  logic [W-1:0] code [N];
  assign i_code = {code[3], code[2], code[1], code[0]};

  mux_n_1_stream_arb #(.WIDTH(W), .N_CH(N), .SEL_W(S)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_mode(i_mode),
    .i_sel_code(i_sel_code), .i_code(i_code), .i_valid(i_valid),
    .o_ready(o_ready), .o_code(o_code), .o_ch(o_ch), .o_valid(o_valid),
    .i_ready(i_ready)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int log_ch[$];
  int log_code[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: output register contents and round-robin pointer as ints.
  int m_valid = 0;
  int m_code  = 0;
  int m_ch    = 0;
  int m_rr    = N - 1;

  always @(negedge i_clk) begin : compare
    int g;
    int ld;
    int exp_ready;
    if (chk_en) begin
      if (o_valid && i_ready) begin
        log_ch.push_back(int'(o_ch));
        log_code.push_back(int'(o_code));
      end
      ld = (i_en && !i_rst && (m_valid == 0 || i_ready)) ? 1 : 0;
      g = -1;
      if (!i_mode) begin
        if (int'(i_sel_code) < N && i_valid[i_sel_code]) g = int'(i_sel_code);
      end else begin
        for (int off = 1; off <= N; off++) begin
          if (g < 0 && i_valid[(m_rr + off) % N]) g = (m_rr + off) % N;
        end
      end
      exp_ready = (ld != 0 && g >= 0) ? (1 << g) : 0;
      chk("model_o_ready", int'(o_ready), exp_ready);
      chk("model_o_valid", int'(o_valid), m_valid);
      chk("model_o_code", int'(o_code), m_code);
      chk("model_o_ch", int'(o_ch), m_ch);
      if (i_rst) begin
        m_valid = 0; m_code = 0; m_ch = 0; m_rr = N - 1;
      end else if (exp_ready != 0) begin
        m_valid = 1; m_code = int'(code[g]); m_ch = g;
        if (i_mode) m_rr = g;
      end else if (m_valid != 0 && i_ready) begin
        m_valid = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic chk_log_ch(input string name, input int exp[]);
    chk({name, "_count"}, log_ch.size(), exp.size());
    for (int i = 0; i < exp.size() && i < log_ch.size(); i++)
      chk(name, log_ch[i], exp[i]);
  endtask

  initial begin
    code[0] = 8'h80; code[1] = 8'h40; code[2] = 8'hC0; code[3] = 8'h20;
    i_rst = 1'b1; i_en = 1'b1; i_mode = 1'b1; i_sel_code = '0;
    i_valid = 4'hF; i_ready = 1'b1;

    // Reset held two cycles with every channel valid.
    @(posedge i_clk);
    #1;
    chk_en = 1'b1;
    chk("rst_o_ready", int'(o_ready), 0);
    chk("rst_o_valid", int'(o_valid), 0);
    chk("rst_o_code", int'(o_code), 0);
    chk("rst_o_ch", int'(o_ch), 0);
    tick(1);
    chk("rst2_o_ready", int'(o_ready), 0);
    i_rst = 1'b0;
    #1;
    chk("first_rr_grant", int'(o_ready), 4'b0001);

    // Round-robin fairness.
    log_ch.delete(); log_code.delete();
    tick(8);
    i_valid = 4'b1010;
    tick(4);
    i_valid = 4'b0000;
    tick(2);
    chk_log_ch("rr_seq", '{0, 1, 2, 3, 0, 1, 2, 3, 1, 3, 1, 3});

    // Fixed select stepped 0..3.
    log_ch.delete(); log_code.delete();
    i_mode = 1'b0; i_valid = 4'hF;
    for (int s = 0; s < N; s++) begin
      i_sel_code = S'(s);
      #1;
      chk("fixed_o_ready", int'(o_ready), 1 << s);
      tick(1);
    end
    i_valid = 4'b0000;
    tick(2);
    chk_log_ch("fixed_ch", '{0, 1, 2, 3});
    if (log_code.size() == 4) begin
      chk("fixed_code0", log_code[0], 8'h80);
      chk("fixed_code1", log_code[1], 8'h40);
      chk("fixed_code2", log_code[2], 8'hC0);
      chk("fixed_code3", log_code[3], 8'h20);
    end

    // Backpressure: 0x40 held three cycles, then next word with no bubble.
    i_sel_code = 2'd1; i_valid = 4'hF; i_ready = 1'b1;
    tick(1);
    i_ready = 1'b0; i_sel_code = 2'd2;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_o_ready", int'(o_ready), 0);
      chk("bp_o_code", int'(o_code), 8'h40);
      chk("bp_o_valid", int'(o_valid), 1);
      tick(1);
    end
    i_ready = 1'b1;
    #1;
    chk("bp_release_ready", int'(o_ready), 4'b0100);
    tick(1);
    chk("bp_next_code", int'(o_code), 8'hC0);
    chk("bp_next_ch", int'(o_ch), 2);
    i_valid = 4'b0000;
    tick(2);

    // Enable low: no accepts, output drains.
    i_mode = 1'b1; i_valid = 4'hF;
    tick(1);
    i_en = 1'b0;
    #1;
    chk("en_off_ready", int'(o_ready), 0);
    tick(1);
    chk("en_off_drain", int'(o_valid), 0);
    tick(1);
    chk("en_off_valid", int'(o_valid), 0);
    chk("en_off_ready2", int'(o_ready), 0);
    i_en = 1'b1;

    // Fixed select of an invalid channel.
    i_mode = 1'b0; i_sel_code = 2'd0; i_valid = 4'b1011;
    tick(1);
    i_sel_code = 2'd2;
    #1;
    chk("badsel_ready", int'(o_ready), 0);
    tick(1);
    chk("badsel_valid", int'(o_valid), 0);

    // Mid-stream reset with a held word.
    i_mode = 1'b1; i_valid = 4'hF; i_ready = 1'b1;
    tick(1);
    chk("mid_pre_ch", int'(o_ch), 1);
    i_ready = 1'b0;
    tick(1);
    i_rst = 1'b1;
    #1;
    chk("mid_rst_ready", int'(o_ready), 0);
    tick(1);
    i_rst = 1'b0;
    chk("mid_rst_valid", int'(o_valid), 0);
    chk("mid_rst_code", int'(o_code), 0);
    #1;
    chk("mid_rst_rr_ready", int'(o_ready), 4'b0001);
    i_ready = 1'b1;
    tick(1);
    chk("mid_rst_ch", int'(o_ch), 0);
    chk("mid_rst_code2", int'(o_code), 8'h80);
    i_valid = 4'b0000;
    tick(2);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
